// File: rtl/enc_stream.sv
// Sign-magnitude to one's-complement lane encoder with a 2-entry output buffer.
// Optional build macro ENC_NEG_ZERO_CANON_EN: negative-zero lanes encode to all-zeros.
module enc_stream #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [LANES-1:0]        out_neg_mask,
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        word_cnt
);

    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned MAG_W  = LANE_W - 1;

    // Per-lane encode: magnitude bits flip when the sign is set.
    function automatic logic [DATA_W-1:0] encode(input logic [DATA_W-1:0] din);
        logic [DATA_W-1:0] dout;
        logic [LANE_W-1:0] lane;
        logic              sign;
        dout = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane = din[k*LANE_W +: LANE_W];
            sign = lane[LANE_W-1];
`ifdef ENC_NEG_ZERO_CANON_EN
            if (sign && (lane[MAG_W-1:0] == '0)) begin
                dout[k*LANE_W +: LANE_W] = '0;
            end else begin
                dout[k*LANE_W +: LANE_W] = {sign, lane[MAG_W-1:0] ^ {MAG_W{sign}}};
            end
`else
            dout[k*LANE_W +: LANE_W] = {sign, lane[MAG_W-1:0] ^ {MAG_W{sign}}};
`endif
        end
        return dout;
    endfunction

    function automatic logic [LANES-1:0] sign_bits(input logic [DATA_W-1:0] d);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            m[k] = d[k*LANE_W + LANE_W - 1];
        end
        return m;
    endfunction

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]  out_neg_mask_q, out_neg_mask_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              push_c, pop_c;

    assign push_c = in_valid && in_ready_q;
    assign pop_c  = out_valid_q && out_ready;

    // Next-state: buffer, pointers and the pre-computed head for the output regs.
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        word_cnt_d     = word_cnt_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = encode(in_data);
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push_c) - 2'(pop_c);

        if (clr_cnt) begin
            word_cnt_d = '0;
        end else if (pop_c) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end

        in_ready_d     = (count_d < 2'd2);
        out_valid_d    = (count_d != 2'd0);
        out_data_d     = mem_d[rd_ptr_d];
        out_neg_mask_d = sign_bits(out_data_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]       <= '0;
            mem_q[1]       <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_neg_mask_q <= '0;
            word_cnt_q     <= '0;
        end else begin
            mem_q[0]       <= mem_d[0];
            mem_q[1]       <= mem_d[1];
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_neg_mask_q <= out_neg_mask_d;
            word_cnt_q     <= word_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_neg_mask = out_neg_mask_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_enc_stream.sv
// Self-checking bench for enc_stream: queue-based reference model plus directed literal checks.
module tb_enc_stream;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_neg_mask;
    logic        clr_cnt;
    logic [3:0]  word_cnt;

    enc_stream #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_neg_mask (out_neg_mask),
        .clr_cnt      (clr_cnt),
        .word_cnt     (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_raw [$];
    logic [31:0] q_enc [$];
    int          m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One's complement of -m is 255-m; negative zero optionally canonicalised.
    function automatic logic [7:0] model_lane(input logic [7:0] b);
        int mag;
        mag = int'(b[6:0]);
        if (!b[7]) return b;
`ifdef ENC_NEG_ZERO_CANON_EN
        if (mag == 0) return 8'h00;
`endif
        return 8'(255 - mag);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = model_lane(w[k*8 +: 8]);
        return r;
    endfunction

    function automatic logic [3:0] model_mask(input logic [31:0] e);
        return {e[31], e[23], e[15], e[7]};
    endfunction

    // Lane decoder: back from one's complement to sign-magnitude.
    function automatic logic [31:0] decode_word(input logic [31:0] e);
        logic [31:0] r;
        logic [7:0]  b;
        for (int k = 0; k < 4; k++) begin
            b = e[k*8 +: 8];
            r[k*8 +: 8] = b[7] ? {1'b1, 7'(255 - int'(b))} : b;
        end
        return r;
    endfunction

    function automatic bit has_neg_zero(input logic [31:0] w);
        bit f;
        f = 1'b0;
        for (int k = 0; k < 4; k++) if (w[k*8 +: 8] == 8'h80) f = 1'b1;
        return f;
    endfunction

    // Compare DUT against the model, then advance the model by the coming edge.
    task automatic model_cycle();
        bit push, pop;
        int sz;
        if (!rst_n) begin
            q_raw.delete();
            q_enc.delete();
            m_cnt = 0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_data", out_data, 32'd0);
            check("rst_word_cnt", 32'(word_cnt), 32'd0);
            return;
        end
        sz = q_enc.size();
        check("m_out_valid", 32'(out_valid), 32'(sz != 0));
        check("m_in_ready", 32'(in_ready), 32'(sz < 2));
        check("m_word_cnt", 32'(word_cnt), 32'(m_cnt));
        if (sz != 0) begin
            check("m_out_data", out_data, q_enc[0]);
            check("m_neg_mask", 32'(out_neg_mask), 32'(model_mask(q_enc[0])));
        end
        push = in_valid && (sz < 2);
        pop  = (sz != 0) && out_ready;
        if (pop) begin
`ifdef ENC_NEG_ZERO_CANON_EN
            if (!has_neg_zero(q_raw[0]))
                check("roundtrip", decode_word(out_data), q_raw[0]);
`else
            check("roundtrip", decode_word(out_data), q_raw[0]);
`endif
            void'(q_raw.pop_front());
            void'(q_enc.pop_front());
        end
        if (clr_cnt) m_cnt = 0;
        else if (pop) m_cnt = (m_cnt + 1) % 16;
        if (push) begin
            q_raw.push_back(in_data);
            q_enc.push_back(model_word(in_data));
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Basic encode
        in_valid = 1'b1; in_data = 32'h7F058183; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", out_data, 32'h7F05FEFC);
        check("basic_mask", 32'(out_neg_mask), 32'h3);
        step();
        check("basic_cnt", 32'(word_cnt), 32'd1);

        // Negative zero
        in_valid = 1'b1; in_data = 32'h80808080;
        step();
        in_valid = 1'b0;
`ifdef ENC_NEG_ZERO_CANON_EN
        check("negzero_data", out_data, 32'h00000000);
        check("negzero_mask", 32'(out_neg_mask), 32'h0);
`else
        check("negzero_data", out_data, 32'hFFFFFFFF);
        check("negzero_mask", 32'(out_neg_mask), 32'hF);
`endif
        step();

        // Back-pressure: A, B accepted, C held until the first pop
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1;
        step();
        in_data = 32'h2;
        step();
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_data = 32'h3;
        step();
        check("bp_head_a", out_data, 32'h1);
        check("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        check("bp_head_b", out_data, 32'h2);
        step();
        in_valid = 1'b0;
        check("bp_head_c", out_data, 32'h3);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Streaming 8 words, mixed signs
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = {8'(i), 8'h80 | 8'(i * 9), 8'(i * 17), 8'h80 | 8'(i)};
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_cnt", 32'(word_cnt), 32'd8);

        // Counter wrap and clear priority
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data = 32'hC0DE0000 | 32'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("cnt_wrap", 32'(word_cnt), 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h8100017F;
        step();
        in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt_clr_prio", 32'(word_cnt), 32'd0);
        check("cnt_clr_popped", 32'(out_valid), 32'd0);

        // Reset mid-stream with a full buffer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD0001;
        step();
        in_data = 32'hDEAD0002;
        step();
        in_valid = 1'b0;
        check("rst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_ready", 32'(in_ready), 32'd1);
        check("rst_async_mask", 32'(out_neg_mask), 32'd0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        step();
        check("rst_no_emit", 32'(out_valid), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_stream.md
Name: enc_stream

Overview:
- Streaming encoder for packed signed lanes. Takes a 32-bit word of four 8-bit sign-magnitude lanes and converts each lane to one's complement, which is the format the lane decoder consumes.
- For each lane, bit[7] (sign) passes through unchanged. Bits[6:0] are XORed with the sign bit.
- Sits on the transmit side, upstream of the lane decoder, with valid/ready on both ports.
- A 2-entry output buffer absorbs back-pressure. A transfer counter is provided for debug.

Parameters:
- LANES, 4: number of lanes per word.
- LANE_W, 8: lane width in bits. MSB is the sign bit. Must be at least 2.
- CNT_W, 16: width of the output-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word. Driven from a register.
- in_data  input  LANES*LANE_W  sign-magnitude lanes. Lane k is bits [k*LANE_W +: LANE_W].
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  LANES*LANE_W  one's-complement lanes, same lane packing as in_data.
- out_neg_mask  output  LANES  sign bit of each output lane.
- clr_cnt  input  1  synchronous clear of word_cnt.
- word_cnt  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both buffer entries are flushed, including any word accepted but not yet delivered.
  - out_valid=0, out_data=0, out_neg_mask=0, word_cnt=0, in_ready=1.
  - Reset asserted mid-operation has the same effect; there is no partial output.
- Transfer rules:
  - Input push occurs when in_valid && in_ready.
  - Output pop occurs when out_valid && out_ready.
- Encoding:
  - Each lane is encoded combinationally at the input and stored already encoded.
  - out[k][LANE_W-2:0] = in[k][LANE_W-2:0] ^ {LANE_W-1{in[k][LANE_W-1]}}.
  - out[k][LANE_W-1] = in[k][LANE_W-1].
- Buffer:
  - 2-entry FIFO with a 1-bit read pointer, a 1-bit write pointer and a 2-bit occupancy count.
  - out_data and out_neg_mask always show the head entry.
  - out_valid = (count != 0), registered.
- Latency:
  - A word pushed into an empty buffer appears on out_valid/out_data the following cycle.
  - There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- in_ready:
  - Registered, equal to (next_count < 2).
  - Deasserts the cycle after a push that fills the buffer (count becomes 2).
  - Reasserts the cycle after a pop from a full buffer.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1 and out_valid=1. Count is unchanged and both pointers advance.
- Boundary cases:
  - Full and pop with no push: count goes to 1.
  - Empty: out_ready is ignored and word_cnt is unchanged.
- Output stability:
  - While out_valid=1 and out_ready=0, out_data and out_neg_mask hold stable.
- word_cnt:
  - Increments by 1 on each pop and wraps modulo 2^CNT_W.
  - clr_cnt has priority: word_cnt becomes 0 and a pop in the same cycle is not counted.
- Ordering: words leave in acceptance order, with no loss and no duplication.

Optional Feature:
- Macro: ENC_NEG_ZERO_CANON_EN.
- When defined:
  - A lane equal to negative zero (sign=1, magnitude=0, e.g. 0x80) encodes to all-zeros (0x00).
  - The corresponding out_neg_mask bit is 0.
- When undefined:
  - Negative zero encodes to all-ones (0xFF), with mask bit 1.
- All other lane values are identical in both builds.

Test Plan:
- Basic encode: reset, then push in_data=0x7F058183 with out_ready=1. Required next cycle: out_valid=1, out_data=0x7F05FEFC, out_neg_mask=4'b0011, and word_cnt=1 after the pop.
- Negative zero: push 0x80808080.
  - Macro undefined: out_data=0xFFFFFFFF, mask=4'b1111.
  - Macro defined: out_data=0x00000000, mask=4'b0000.
- Back-pressure: hold out_ready=0 and present words A=0x00000001, B=0x00000002, C=0x00000003 back-to-back.
  - A and B are accepted; in_ready goes 0 the cycle after B; C is held.
  - Then raise out_ready=1. Outputs are A, B, C in order, each exactly once, and in_ready reasserts the cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 continuously for 8 words. Required: one word per cycle after 1-cycle latency and word_cnt=8.
- Counter: with CNT_W=4, 17 pops gives word_cnt=1. Asserting clr_cnt in the same cycle as a pop gives word_cnt=0.
- Reset mid-stream: with the buffer full, pulse rst_n low for 1 cycle. Required: out_valid=0 and in_ready=1 immediately, and the buffered words are never emitted. Round-trip each output through the lane decoder and check it equals the input, excluding negative zero when the macro is defined.
